// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory arbiter.
// Imported by the interface, the round-robin picker and the top.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 16;
    localparam int DW_DEF   = 32;
    localparam int TMO_DEF  = 255;

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side and memory-side bus of the arbiter.
// slave = arbiter view, master = requesters/BFM view.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic               rsp_err;
    logic [DW-1:0]      rsp_rdata;

    logic               mem_valid;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [DW-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1
// with wrap and returns the first requester found.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] last_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int IW = $clog2(NREQ);

    int   j;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(last_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/mem_arb.sv
// N-way arbiter sharing one memory BFM, one transaction in flight.
// Reads time out after TMO wait cycles and return err with zero data.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int TMO  = TMO_DEF
) (
    input logic      clk,
    input logic      rst_n,
    mem_arb_if.slave bus
);

    localparam int         IW    = $clog2(NREQ);
    localparam logic [7:0] TMO_C = 8'(TMO);

    state_e          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i  (bus.req_valid),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    we_d    = bus.req_we[pick_idx];
                    addr_d  = bus.req_addr[int'(pick_idx)*AW +: AW];
                    wdata_d = bus.req_wdata[int'(pick_idx)*DW +: DW];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    state_d = we_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Return data wins over a coincident timeout
                if (bus.mem_rvalid) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TMO_C) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (rst_n && state_q == IDLE) ? pick_gnt : '0;
    assign bus.rsp_valid = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_valid = (state_q == ISSUE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: round-robin order, write/read latency,
// timeout, ISSUE back-pressure and reset abort during WAIT.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   hs_cnt;
    int   rsp_cnt;
    int   hs0;
    int   rsp0;

    mem_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    mem_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        hs_cnt  = 0;
        rsp_cnt = 0;
    end
    always @(negedge clk) begin
        if (bus.mem_valid && bus.mem_ready) hs_cnt = hs_cnt + 1;
        if (bus.rsp_valid != '0) rsp_cnt = rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'h0);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'h0);
        chk({tag, "_rdata"}, bus.rsp_rdata, 32'h0);
        chk({tag, "_memv"}, 32'(bus.mem_valid), 32'h0);
        chk({tag, "_memwe"}, 32'(bus.mem_we), 32'h0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'h0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.req_we     = 4'b1111;
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW]  = 16'h0100 + 16'(i);
            bus.req_wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end
        #1;
        chk_all_zero("rst0");
        cyc();
        cyc();
        chk_all_zero("rst1");

        // All four requesting from reset: grants 0,1,2,3,0
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NREQ;
            chk("rr_ready", 32'(bus.req_ready), 32'(1) << g);
            cyc();
            chk("rr_memv", 32'(bus.mem_valid), 32'h1);
            chk("rr_addr", 32'(bus.mem_addr), 32'h0100 + 32'(g));
            cyc();
            chk("rr_rspv", 32'(bus.rsp_valid), 32'(1) << g);
            chk("rr_rdata", bus.rsp_rdata, 32'h0);
            if (k == 4) bus.req_valid = 4'b0000;
            cyc();
        end

        // Requester 1 write, minimum latency
        bus.req_valid          = 4'b0010;
        bus.req_we             = 4'b0010;
        bus.req_addr[16 +: 16] = 16'h0010;
        bus.req_wdata[32 +: 32] = 32'hDEADBEEF;
        #1;
        chk("wr_ready", 32'(bus.req_ready), 32'h2);
        cyc();
        bus.req_valid = 4'b0000;
        #1;
        chk("wr_memv", 32'(bus.mem_valid), 32'h1);
        chk("wr_memwe", 32'(bus.mem_we), 32'h1);
        chk("wr_addr", 32'(bus.mem_addr), 32'h0010);
        chk("wr_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("wr_ready1", 32'(bus.req_ready), 32'h0);
        cyc();
        chk("wr_rspv", 32'(bus.rsp_valid), 32'h2);
        chk("wr_err", 32'(bus.rsp_err), 32'h0);
        chk("wr_memv2", 32'(bus.mem_valid), 32'h0);
        cyc();
        chk("wr_rspv3", 32'(bus.rsp_valid), 32'h0);

        // Requester 2 read, data back 3 cycles after handshake
        bus.req_valid          = 4'b0100;
        bus.req_we             = 4'b0000;
        bus.req_addr[32 +: 16] = 16'h0010;
        #1;
        chk("rd_ready", 32'(bus.req_ready), 32'h4);
        cyc();
        bus.req_valid = 4'b0000;
        #1;
        chk("rd_memv", 32'(bus.mem_valid), 32'h1);
        chk("rd_memwe", 32'(bus.mem_we), 32'h0);
        chk("rd_addr", 32'(bus.mem_addr), 32'h0010);
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (c == 2) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hDEADBEEF;
            end
            chk("rd_wait_memv", 32'(bus.mem_valid), 32'h0);
            chk("rd_wait_rspv", 32'(bus.rsp_valid), 32'h0);
        end
        cyc();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        chk("rd_rspv", 32'(bus.rsp_valid), 32'h4);
        chk("rd_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(bus.rsp_err), 32'h0);
        cyc();

        // Requester 3 read never answered: timeout after 4 WAIT cycles
        bus.req_valid = 4'b1000;
        #1;
        chk("to_ready", 32'(bus.req_ready), 32'h8);
        cyc();
        bus.req_valid = 4'b0000;
        chk("to_memv", 32'(bus.mem_valid), 32'h1);
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("to_wait_memv", 32'(bus.mem_valid), 32'h0);
            chk("to_wait_rspv", 32'(bus.rsp_valid), 32'h0);
        end
        cyc();
        chk("to_rspv", 32'(bus.rsp_valid), 32'h8);
        chk("to_err", 32'(bus.rsp_err), 32'h1);
        chk("to_rdata", bus.rsp_rdata, 32'h0);
        cyc();

        // Next request (requester 0 read) at minimum latency
        bus.req_valid = 4'b0001;
        #1;
        chk("nx_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = 4'b0000;
        chk("nx_memv", 32'(bus.mem_valid), 32'h1);
        cyc();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        cyc();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        chk("nx_rspv", 32'(bus.rsp_valid), 32'h1);
        chk("nx_err", 32'(bus.rsp_err), 32'h0);
        chk("nx_rdata", bus.rsp_rdata, 32'h1234_5678);
        cyc();

        // Requester 1 write held off by mem_ready=0 for 5 cycles
        hs0  = hs_cnt;
        rsp0 = rsp_cnt;
        bus.req_valid           = 4'b0010;
        bus.req_we              = 4'b0010;
        bus.req_addr[16 +: 16]  = 16'h0ABC;
        bus.req_wdata[32 +: 32] = 32'hCAFEF00D;
        bus.mem_ready           = 1'b0;
        #1;
        chk("bp_ready", 32'(bus.req_ready), 32'h2);
        for (int c = 0; c < 5; c++) begin
            cyc();
            bus.req_valid = 4'b0000;
            chk("bp_memv", 32'(bus.mem_valid), 32'h1);
            chk("bp_addr", 32'(bus.mem_addr), 32'h0ABC);
            chk("bp_wdata", bus.mem_wdata, 32'hCAFEF00D);
            chk("bp_rspv", 32'(bus.rsp_valid), 32'h0);
        end
        cyc();
        bus.mem_ready = 1'b1;
        chk("bp_memv6", 32'(bus.mem_valid), 32'h1);
        cyc();
        chk("bp_rspv7", 32'(bus.rsp_valid), 32'h2);
        cyc();
        cyc();
        chk("bp_hs", 32'(hs_cnt - hs0), 32'h1);
        chk("bp_rspcnt", 32'(rsp_cnt - rsp0), 32'h1);

        // Reset pulse during WAIT of a requester 2 read
        rsp0 = rsp_cnt;
        bus.req_valid = 4'b0100;
        bus.req_we    = 4'b0000;
        #1;
        chk("ra_ready", 32'(bus.req_ready), 32'h4);
        cyc();
        bus.req_valid = 4'b0000;
        cyc();
        chk("ra_wait_memv", 32'(bus.mem_valid), 32'h0);
        cyc();
        bus.req_valid = 4'b1111;
        rst_n         = 1'b0;
        #1;
        chk_all_zero("ra_rst");
        cyc();
        bus.req_valid  = 4'b0000;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        rst_n          = 1'b1;
        cyc();
        chk("ra_stray_rspv", 32'(bus.rsp_valid), 32'h0);
        chk("ra_stray_memv", 32'(bus.mem_valid), 32'h0);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        cyc();
        chk("ra_stray_rdata", bus.rsp_rdata, 32'h0);
        bus.req_valid = 4'b0101;
        #1;
        chk("ra_ready0", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = 4'b0000;
        chk("ra_addr0", 32'(bus.mem_addr), 32'h0100);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("ra_rspcnt", 32'(rsp_cnt - rsp0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
